// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - HD44780 command codes, delays and FSM encodings
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLR      = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] ROW0     = 8'h80;
  localparam logic [7:0] ROW1     = 8'hC0;

  localparam int T_PWR  = 15000;
  localparam int T_FS1  = 4100;
  localparam int T_FS2  = 100;
  localparam int T_EXEC = 50;
  localparam int T_CLR  = 2000;

  localparam logic [2:0] INIT_LAST = 3'd6;

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_INIT_SEQ,
    ST_IDLE,
    ST_CLR,
    ST_ADDR,
    ST_CHARS
  } lcd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_WAIT
  } tx_phase_t;

  function automatic logic [7:0] init_byte(input logic [2:0] step);
    case (step)
      3'd4:    return DISP_ON;
      3'd5:    return CLR;
      3'd6:    return ENTRY;
      default: return FUNC_SET;
    endcase
  endfunction

  function automatic int init_wait_us(input logic [2:0] step);
    case (step)
      3'd0:    return T_FS1;
      3'd1:    return T_FS2;
      3'd5:    return T_CLR;
      default: return T_EXEC;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// rtl/lcd_byte_tx.sv - single HD44780 byte: setup, E pulse, exec wait
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int CYC_US = 50,
  parameter int DW     = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          rs,
  input  logic [7:0]    byte_val,
  input  logic [DW-1:0] wait_cycles,
  output logic          busy,
  output logic          fin,
  output logic          lcd_rs,
  output logic          lcd_e,
  output logic [7:0]    lcd_db
);

  tx_phase_t     phase;
  logic [DW-1:0] cnt;
  logic [DW-1:0] wait_q;

  // Latch RS/DB on start, one setup cycle, E high CYC_US cycles, then hold RS/DB for the exec wait
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= TX_IDLE;
      cnt    <= '0;
      wait_q <= '0;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_db <= 8'h00;
    end else begin
      case (phase)
        TX_IDLE: begin
          if (start) begin
            lcd_rs <= rs;
            lcd_db <= byte_val;
            wait_q <= wait_cycles - DW'(1);
            phase  <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          lcd_e <= 1'b1;
          cnt   <= DW'(CYC_US - 1);
          phase <= TX_PULSE;
        end
        TX_PULSE: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= wait_q;
            phase <= TX_WAIT;
          end else begin
            cnt <= cnt - DW'(1);
          end
        end
        TX_WAIT: begin
          if (cnt == '0) phase <= TX_IDLE;
          else           cnt   <= cnt - DW'(1);
        end
        default: phase <= TX_IDLE;
      endcase
    end
  end

  // fin marks the last exec-wait cycle so the sequencer can queue the next byte
  always_comb begin
    busy = (phase != TX_IDLE);
    fin  = (phase == TX_WAIT) && (cnt == '0);
  end

endmodule

// File: rtl/hd44780_ctrl.sv
// rtl/hd44780_ctrl.sv - HD44780 init and command sequencer over lcd_byte_tx
module hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int NCHARS   = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                write,
  input  logic                chrow,
  input  logic [8*NCHARS-1:0] data,
  output logic                done,
  output logic                lcd_rs,
  output logic                lcd_e,
  output logic [7:0]          lcd_db
);

  localparam int CYC_US = CLK_FREQ / 1000000;
  localparam int DW     = $clog2(T_PWR * CYC_US + 1);
  localparam int IW     = (NCHARS > 1) ? $clog2(NCHARS) : 1;

  lcd_state_t          state, state_nxt;
  logic [DW-1:0]       dly;
  logic [2:0]          step;
  logic [IW-1:0]       idx;
  logic                row, sent, wr_mode;
  logic [8*NCHARS-1:0] text_q;
  logic                start, tx_rs, tx_busy, tx_fin;
  logic [7:0]          tx_byte;
  logic [DW-1:0]       tx_wait;
  logic                acc_clr, acc_row, acc_wr, last_idx;

  assign acc_clr  = (state == ST_IDLE) && clear;
  assign acc_row  = (state == ST_IDLE) && !clear && chrow;
  assign acc_wr   = (state == ST_IDLE) && !clear && !chrow && write;
  assign last_idx = (idx == IW'(NCHARS - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT_WAIT;
    else          state <= state_nxt;
  end

  // Next state: advance on the final exec-wait cycle of each byte
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT_WAIT: if (dly == '0) state_nxt = ST_INIT_SEQ;
      ST_INIT_SEQ:  if (tx_fin && step == INIT_LAST) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (clear)                  state_nxt = ST_CLR;
        else if (chrow || write)    state_nxt = ST_ADDR;
      end
      ST_CLR:       if (tx_fin) state_nxt = ST_IDLE;
      ST_ADDR:      if (tx_fin) state_nxt = wr_mode ? ST_CHARS : ST_IDLE;
      ST_CHARS:     if (tx_fin && last_idx) state_nxt = ST_IDLE;
      default:      state_nxt = ST_INIT_WAIT;
    endcase
  end

  // Outputs: byte selection for the current state and the start handshake
  always_comb begin
    done    = (state == ST_IDLE);
    tx_rs   = 1'b0;
    tx_byte = 8'h00;
    tx_wait = DW'(T_EXEC * CYC_US);
    case (state)
      ST_INIT_SEQ: begin
        tx_byte = init_byte(step);
        tx_wait = DW'(init_wait_us(step) * CYC_US);
      end
      ST_CLR: begin
        tx_byte = CLR;
        tx_wait = DW'(T_CLR * CYC_US);
      end
      ST_ADDR:  tx_byte = row ? ROW1 : ROW0;
      ST_CHARS: begin
        tx_rs   = 1'b1;
        tx_byte = text_q[8*(NCHARS-1-int'(idx)) +: 8];
      end
      default: ;
    endcase
    start = !sent && !tx_busy &&
            (state inside {ST_INIT_SEQ, ST_CLR, ST_ADDR, ST_CHARS});
  end

  // Datapath: power-on delay, init step, char index, row, latched text
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly     <= DW'(T_PWR * CYC_US - 1);
      step    <= '0;
      idx     <= '0;
      row     <= 1'b0;
      sent    <= 1'b0;
      wr_mode <= 1'b0;
      text_q  <= '0;
    end else begin
      if (state == ST_INIT_WAIT && dly != '0) dly <= dly - DW'(1);
      if (tx_fin)     sent <= 1'b0;
      else if (start) sent <= 1'b1;
      if (state == ST_INIT_SEQ && tx_fin) step <= step + 3'd1;
      if (state == ST_CHARS && tx_fin && !last_idx) idx <= idx + IW'(1);
      if (state == ST_IDLE) wr_mode <= acc_wr;
      if (acc_clr) row <= 1'b0;
      if (acc_row) row <= ~row;
      if (acc_wr) begin
        text_q <= data;
        idx    <= '0;
      end
    end
  end

  lcd_byte_tx #(.CYC_US(CYC_US), .DW(DW)) u_tx (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .rs          (tx_rs),
    .byte_val    (tx_byte),
    .wait_cycles (tx_wait),
    .busy        (tx_busy),
    .fin         (tx_fin),
    .lcd_rs      (lcd_rs),
    .lcd_e       (lcd_e),
    .lcd_db      (lcd_db)
  );

endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb/tb_hd44780_ctrl.sv - randomized self-checking bench for hd44780_ctrl
module tb_hd44780_ctrl;

  localparam int CLK_FREQ = 2000000;
  localparam int NCHARS   = 20;
  localparam int CYC_US   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0, write = 1'b0, chrow = 1'b0;
  logic [8*NCHARS-1:0] data = '0;
  logic done, lcd_rs, lcd_e;
  logic [7:0] lcd_db;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = 0;

  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] txt[NCHARS];
  logic       model_row = 1'b0;

  logic       e_prev = 1'b0;
  logic       have_fall = 1'b0;
  int         e_width = 0;
  int         last_fall = 0;
  int         first_rise = -1;
  logic [8:0] last_cap = '0;
  logic [8:0] rise_val = '0;

  hd44780_ctrl #(.CLK_FREQ(CLK_FREQ), .NCHARS(NCHARS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .write   (write),
    .chrow   (chrow),
    .data    (data),
    .done    (done),
    .lcd_rs  (lcd_rs),
    .lcd_e   (lcd_e),
    .lcd_db  (lcd_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ge(input string tag, input int obs, input int min);
    checks++;
    assert (obs >= min) else begin
      errors++;
      $error("FAIL %s observed=%0d expected>=%0d", tag, obs, min);
    end
  endtask

  // HD44780 datasheet: after Clear Display the controller needs 2 ms, everything else 50 us
  function automatic int min_gap(input logic [8:0] prev);
    return (prev == {1'b0, 8'h01}) ? 2000 * CYC_US : 50 * CYC_US;
  endfunction

  // Bus monitor: captures each byte on the E falling edge, checks E width, hold and exec gap
  always @(negedge clk) begin
    if (!reset_n) begin
      e_prev = 1'b0;
      have_fall = 1'b0;
      e_width = 0;
      first_rise = -1;
    end else begin
      if (lcd_e && !e_prev) begin
        if (first_rise < 0) first_rise = cyc;
        if (have_fall) chk_ge("exec_gap", cyc - last_fall, min_gap(last_cap));
        rise_val = {lcd_rs, lcd_db};
        e_width = 0;
      end
      if (lcd_e) e_width++;
      if (!lcd_e && e_prev) begin
        chk_ge("e_width", e_width, CYC_US);
        chk("rs_db_hold", {23'd0, lcd_rs, lcd_db}, {23'd0, rise_val});
        cap_q.push_back({lcd_rs, lcd_db});
        last_cap = {lcd_rs, lcd_db};
        last_fall = cyc;
        have_fall = 1'b1;
      end
      e_prev = lcd_e;
    end
  end

  function automatic logic [8*NCHARS-1:0] pack_text();
    logic [8*NCHARS-1:0] v;
    for (int i = 0; i < NCHARS; i++) v[8*NCHARS-1-8*i -: 8] = txt[i];
    return v;
  endfunction

  task automatic rand_text();
    for (int i = 0; i < NCHARS; i++) txt[i] = 8'($urandom_range(32, 126));
  endtask

  task automatic expect_addr();
    exp_q.push_back({1'b0, model_row ? 8'hC0 : 8'h80});
  endtask

  task automatic expect_write();
    expect_addr();
    for (int i = 0; i < NCHARS; i++) exp_q.push_back({1'b1, txt[i]});
  endtask

  task automatic check_caps(input string tag);
    chk({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk({tag, "_byte"}, {23'd0, cap_q[i]}, {23'd0, exp_q[i]});
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse(input logic c, input logic w, input logic r);
    @(posedge clk); #1;
    clear = c; write = w; chrow = r;
    @(posedge clk); #1;
    clear = 1'b0; write = 1'b0; chrow = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout observed done=%b expected 1", tag, done);
    end
    done_cyc = cyc;
  endtask

  initial begin
    int rel;
    int n;
    string s;
    logic [7:0] init_exp[7];
    init_exp = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_done", done, 0);
    chk("reset_e", lcd_e, 0);
    chk("reset_rs", lcd_rs, 0);
    chk("reset_db", lcd_db, 0);

    // 1. Power-on init
    @(posedge clk); #1;
    reset_n = 1'b1;
    rel = cyc;
    wait_done("init", 50000);
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, init_exp[i]});
    chk_ge("first_e_rise", first_rise - rel, 15000 * CYC_US);
    chk_ge("init_done_gap", done_cyc - last_fall, 50 * CYC_US);
    check_caps("init");

    // 2. HELLO WORLD on row 0
    s = "HELLO WORLD";
    for (int i = 0; i < NCHARS; i++) txt[i] = (i < s.len()) ? s[i] : 8'h20;
    data = pack_text();
    expect_write();
    pulse(1'b0, 1'b1, 1'b0);
    wait_done("hello", 5000);
    check_caps("hello");

    // 3. chrow, write on row 1, chrow back
    model_row = ~model_row;
    expect_addr();
    pulse(1'b0, 1'b0, 1'b1);
    wait_done("chrow1", 1000);
    check_caps("chrow1");
    rand_text();
    data = pack_text();
    expect_write();
    pulse(1'b0, 1'b1, 1'b0);
    wait_done("write_row1", 5000);
    check_caps("write_row1");
    model_row = ~model_row;
    expect_addr();
    pulse(1'b0, 1'b0, 1'b1);
    wait_done("chrow2", 1000);
    check_caps("chrow2");

    // 4. Move to row 1, then all three strobes together: only clear is taken
    model_row = ~model_row;
    expect_addr();
    pulse(1'b0, 1'b0, 1'b1);
    wait_done("chrow3", 1000);
    check_caps("chrow3");
    model_row = 1'b0;
    exp_q.push_back({1'b0, 8'h01});
    pulse(1'b1, 1'b1, 1'b1);
    wait_done("clear_prio", 8000);
    chk_ge("clear_done_gap", done_cyc - last_fall, 2000 * CYC_US);
    check_caps("clear_prio");

    // 5. Write on row 0; strobe and data changes while busy have no effect
    rand_text();
    data = pack_text();
    expect_write();
    pulse(1'b0, 1'b1, 1'b0);
    rand_text();
    data = pack_text();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    wait_done("write_latched", 5000);
    check_caps("write_latched");

    // 6. Asynchronous reset while E is high mid-CHARS
    pulse(1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(cap_q.size() >= 3 && lcd_e === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_chars_e_high", lcd_e, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_e", lcd_e, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_db", lcd_db, 0);
    repeat (2) @(negedge clk);
    cap_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    rel = cyc;
    n = 0;
    while (cap_q.size() < 1 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_count", (cap_q.size() >= 1) ? 1 : 0, 1);
    chk("reinit_first_byte", {23'd0, cap_q[0]}, {23'd0, 1'b0, 8'h38});
    chk_ge("reinit_first_rise", first_rise - rel, 15000 * CYC_US);
    chk("reinit_done_low", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
